// File: rtl/msrv32_trap_control.sv
// Machine-mode trap sequencer: detects exceptions, interrupts and MRET, then
// steers the PC mux, pipeline flush and CSR update strobes for one cycle.
module msrv32_trap_control (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       trap_taken_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out
);

  // state       | meaning
  // RESET       | boot: PC from boot address, pipeline flushed
  // OPERATING   | normal execution, traps and MRET accepted
  // TRAP_TAKEN  | one cycle: jump to vector, write mepc/mcause, clear MIE
  // TRAP_RETURN | one cycle: jump to mepc, set MIE
  typedef enum logic [1:0] {RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN} state_t;

  state_t state, next_state;

  logic is_system, is_ecall, is_ebreak, is_mret_instr, is_mret;
  logic mei, msi, mti, exc, irq;
  logic [3:0] cause_next;
  logic       mis_next;

  assign is_system     = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                         (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign is_ecall      = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
  assign is_ebreak     = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
  assign is_mret_instr = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

  assign mei = meie_in & meip_in;
  assign msi = msie_in & msip_in;
  assign mti = mtie_in & mtip_in;

  assign exc = misaligned_instr_in | illegal_instr_in | is_ebreak |
               misaligned_load_in | misaligned_store_in | is_ecall;
  assign irq = mie_in & (mei | msi | mti);

  assign trap_taken_out = (state == OPERATING) & (exc | irq);
  assign is_mret        = (state == OPERATING) & is_mret_instr & ~trap_taken_out;

  // Exceptions outrank interrupts; within each group the order is fixed.
  always_comb begin
    cause_next = 4'd0;
    mis_next   = 1'b0;
    if (misaligned_instr_in) begin
      cause_next = 4'd0;
      mis_next   = 1'b1;
    end else if (illegal_instr_in) begin
      cause_next = 4'd2;
    end else if (is_ebreak) begin
      cause_next = 4'd3;
    end else if (misaligned_load_in) begin
      cause_next = 4'd4;
      mis_next   = 1'b1;
    end else if (misaligned_store_in) begin
      cause_next = 4'd6;
      mis_next   = 1'b1;
    end else if (is_ecall) begin
      cause_next = 4'd11;
    end else if (mei) begin
      cause_next = 4'd11;
    end else if (msi) begin
      cause_next = 4'd3;
    end else if (mti) begin
      cause_next = 4'd7;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      cause_out                <= 4'd0;
      i_or_e_out               <= 1'b0;
      misaligned_exception_out <= 1'b0;
    end else if (trap_taken_out) begin
      cause_out                <= cause_next;
      i_or_e_out               <= ~exc;
      misaligned_exception_out <= mis_next;
    end
  end

  always_comb begin
    next_state      = state;
    pc_src_out      = 2'b11;
    flush_out       = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state)
      RESET: begin
        next_state = OPERATING;
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
      end
      OPERATING: begin
        if (trap_taken_out)  next_state = TRAP_TAKEN;
        else if (is_mret)    next_state = TRAP_RETURN;
        pc_src_out      = 2'b11;
        instret_inc_out = ~trap_taken_out;
      end
      TRAP_TAKEN: begin
        next_state    = OPERATING;
        pc_src_out    = 2'b10;
        flush_out     = 1'b1;
        set_epc_out   = 1'b1;
        set_cause_out = 1'b1;
        mie_clear_out = 1'b1;
      end
      TRAP_RETURN: begin
        next_state  = OPERATING;
        pc_src_out  = 2'b01;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: begin
        next_state = RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_msrv32_trap_control.sv
// Scoreboard bench for msrv32_trap_control: directed traps and MRETs push the
// expected one-cycle response; a negedge monitor pops and checks it.
module tb_msrv32_trap_control;

  logic       clk, rst;
  logic       illegal, mis_load, mis_store, mis_instr;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs2, rs1, rd;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic       trap_taken, flush, set_epc, set_cause, i_or_e, mie_clear, mie_set, mis_exc, instret_inc;
  logic [1:0] pc_src;
  logic [3:0] cause;

  typedef struct {
    logic       is_mret;
    logic [3:0] cause;
    logic       ioe;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  msrv32_trap_control dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .illegal_instr_in         (illegal),
    .misaligned_load_in       (mis_load),
    .misaligned_store_in      (mis_store),
    .misaligned_instr_in      (mis_instr),
    .opcode_6_to_2_in         (opcode),
    .funct3_in                (funct3),
    .funct7_in                (funct7),
    .rs2_addr_in              (rs2),
    .rs1_addr_in              (rs1),
    .rd_addr_in               (rd),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .meip_in                  (meip),
    .mtip_in                  (mtip),
    .msip_in                  (msip),
    .trap_taken_out           (trap_taken),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .set_epc_out              (set_epc),
    .set_cause_out            (set_cause),
    .cause_out                (cause),
    .i_or_e_out               (i_or_e),
    .mie_clear_out            (mie_clear),
    .mie_set_out              (mie_set),
    .misaligned_exception_out (mis_exc),
    .instret_inc_out          (instret_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_inputs();
    illegal = 0; mis_load = 0; mis_store = 0; mis_instr = 0;
    opcode = 5'b01100; funct3 = 0; funct7 = 0; rs2 = 0; rs1 = 0; rd = 0;
    mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
  endtask

  task automatic set_system(input logic [6:0] f7, input logic [4:0] r2);
    opcode = 5'b11100; funct3 = 3'b000; rs1 = 0; rd = 0; funct7 = f7; rs2 = r2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already driven for an OPERATING cycle; confirm detection,
  // enqueue the expected TRAP_TAKEN response and step through it.
  task automatic expect_trap(input string name, input logic [3:0] c, input logic ioe, input logic mis);
    exp_t e;
    @(negedge clk);
    check({name, " trap_taken"}, {3'b0, trap_taken}, 4'd1);
    check({name, " instret_inc"}, {3'b0, instret_inc}, 4'd0);
    e.is_mret = 0; e.cause = c; e.ioe = ioe; e.mis = mis;
    exp_q.push_back(e);
    next_cycle();
    clear_inputs();
    next_cycle();
    check({name, " back pc_src"}, {2'b0, pc_src}, 4'd3);
  endtask

  // Monitor: TRAP_TAKEN and TRAP_RETURN cycles are the DUT's "output valid".
  always @(negedge clk) begin
    if (!rst && (set_cause || mie_set)) begin
      if (exp_q.size() == 0) begin
        check("unexpected response", {3'b0, set_cause}, 4'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.is_mret) begin
          check("tt set_cause", {3'b0, set_cause}, 4'd1);
          check("tt pc_src", {2'b0, pc_src}, 4'd2);
          check("tt flush", {3'b0, flush}, 4'd1);
          check("tt set_epc", {3'b0, set_epc}, 4'd1);
          check("tt mie_clear", {3'b0, mie_clear}, 4'd1);
          check("tt mie_set", {3'b0, mie_set}, 4'd0);
          check("tt cause", cause, e.cause);
          check("tt i_or_e", {3'b0, i_or_e}, {3'b0, e.ioe});
          check("tt misaligned", {3'b0, mis_exc}, {3'b0, e.mis});
        end else begin
          check("ret mie_set", {3'b0, mie_set}, 4'd1);
          check("ret pc_src", {2'b0, pc_src}, 4'd1);
          check("ret flush", {3'b0, flush}, 4'd1);
          check("ret set_epc", {3'b0, set_epc}, 4'd0);
          check("ret set_cause", {3'b0, set_cause}, 4'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    clear_inputs();
    rst = 1;
    @(negedge clk);
    check("rst pc_src", {2'b0, pc_src}, 4'd0);
    check("rst flush", {3'b0, flush}, 4'd1);
    check("rst cause", cause, 4'd0);
    check("rst instret", {3'b0, instret_inc}, 4'd0);
    rst = 0;
    #1;
    check("post-rst pc_src before edge", {2'b0, pc_src}, 4'd0);
    next_cycle();
    check("operating pc_src", {2'b0, pc_src}, 4'd3);
    check("operating instret", {3'b0, instret_inc}, 4'd1);

    // ECALL
    set_system(7'b0000000, 5'b00000);
    expect_trap("ecall", 4'd11, 1'b0, 1'b0);

    // SYSTEM-like encoding with rs1 != 0 is not ECALL
    set_system(7'b0000000, 5'b00000);
    rs1 = 5'd3;
    @(negedge clk);
    check("ecall rs1!=0 no trap", {3'b0, trap_taken}, 4'd0);
    check("ecall rs1!=0 instret", {3'b0, instret_inc}, 4'd1);
    next_cycle();
    clear_inputs();

    // EBREAK
    set_system(7'b0000000, 5'b00001);
    expect_trap("ebreak", 4'd3, 1'b0, 1'b0);

    // Exception beats interrupt; illegal beats misaligned load
    illegal = 1; mis_load = 1; mie = 1; meie = 1; meip = 1;
    expect_trap("exc_vs_irq", 4'd2, 1'b0, 1'b0);

    // Misaligned instruction is highest priority
    mis_instr = 1; illegal = 1; mis_store = 1;
    expect_trap("mis_instr", 4'd0, 1'b0, 1'b1);

    mis_load = 1;
    expect_trap("mis_load", 4'd4, 1'b0, 1'b1);

    // MSI beats MTI
    mie = 1; msie = 1; msip = 1; mtie = 1; mtip = 1;
    expect_trap("msi_vs_mti", 4'd3, 1'b1, 1'b0);

    mie = 1; mtie = 1; mtip = 1;
    expect_trap("mti", 4'd7, 1'b1, 1'b0);

    // Global MIE off masks interrupts
    mie = 0; msie = 1; msip = 1; mtie = 1; mtip = 1; meie = 1; meip = 1;
    @(negedge clk);
    check("mie0 no trap", {3'b0, trap_taken}, 4'd0);
    check("mie0 instret", {3'b0, instret_inc}, 4'd1);
    next_cycle();
    clear_inputs();

    // MRET
    set_system(7'b0011000, 5'b00010);
    @(negedge clk);
    check("mret no trap", {3'b0, trap_taken}, 4'd0);
    e.is_mret = 1; e.cause = 0; e.ioe = 0; e.mis = 0;
    exp_q.push_back(e);
    next_cycle();
    clear_inputs();
    next_cycle();
    check("mret back pc_src", {2'b0, pc_src}, 4'd3);

    // MRET with a pending external interrupt: the interrupt wins
    set_system(7'b0011000, 5'b00010);
    mie = 1; meie = 1; meip = 1;
    expect_trap("mret_vs_mei", 4'd11, 1'b1, 1'b0);

    // Misaligned store held through TRAP_TAKEN: no second detection
    mis_store = 1;
    @(negedge clk);
    check("store trap_taken", {3'b0, trap_taken}, 4'd1);
    e.is_mret = 0; e.cause = 4'd6; e.ioe = 0; e.mis = 1;
    exp_q.push_back(e);
    next_cycle();
    @(negedge clk);
    check("store held in TRAP_TAKEN", {3'b0, trap_taken}, 4'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("store held back pc_src", {2'b0, pc_src}, 4'd3);
    check("store cause holds", cause, 4'd6);
    next_cycle();

    // Reset in the middle of TRAP_TAKEN aborts the sequence
    mis_instr = 1;
    @(negedge clk);
    check("pre-abort trap_taken", {3'b0, trap_taken}, 4'd1);
    next_cycle();
    clear_inputs();
    rst = 1;
    #1;
    check("abort pc_src", {2'b0, pc_src}, 4'd0);
    check("abort flush", {3'b0, flush}, 4'd1);
    check("abort set_epc", {3'b0, set_epc}, 4'd0);
    check("abort set_cause", {3'b0, set_cause}, 4'd0);
    check("abort mie_clear", {3'b0, mie_clear}, 4'd0);
    check("abort cause", cause, 4'd0);
    check("abort i_or_e", {3'b0, i_or_e}, 4'd0);
    check("abort misaligned", {3'b0, mis_exc}, 4'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check("release pc_src", {2'b0, pc_src}, 4'd0);
    next_cycle();
    check("release operating pc_src", {2'b0, pc_src}, 4'd3);
    check("release instret", {3'b0, instret_inc}, 4'd1);

    next_cycle();
    next_cycle();
    check("scoreboard drained", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_trap_control.md
# msrv32_trap_control

Machine-mode trap sequencer for the MSRV32 core. It monitors the decoder's exception flags, the current SYSTEM instruction fields and the machine interrupt lines. It decides when a trap or MRET occurs and steers the PC mux, pipeline flush and CSR-file update strobes. Its `trap_taken_out` feeds the decoder's `trap_taken_in` so that stores are suppressed in a trapping cycle.

## Interface
- No parameters; the cause encodings are fixed by the RISC-V privileged spec.
- `ms_riscv32_mp_clk_in` in 1 — core clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_in` in 1 — reset, asynchronous, active-high.
- `illegal_instr_in` in 1 — decoder illegal-instruction flag.
- `misaligned_load_in`, `misaligned_store_in` in 1 each — decoder misaligned load and store flags.
- `misaligned_instr_in` in 1 — fetch-target misalignment from the branch unit.
- `opcode_6_to_2_in` in 5 — instruction opcode bits [6:2].
- `funct3_in` in 3 — instruction bits [14:12].
- `funct7_in` in 7 — instruction bits [31:25].
- `rs2_addr_in`, `rs1_addr_in`, `rd_addr_in` in 5 each — instruction register fields.
- `mie_in` in 1 — mstatus.MIE.
- `meie_in`, `mtie_in`, `msie_in` in 1 each — mie register enable bits.
- `meip_in`, `mtip_in`, `msip_in` in 1 each — interrupt pending lines.
- `trap_taken_out` out 1 — combinational trap-detected strobe.
- `pc_src_out` out 2 — PC mux select: 00 boot, 01 mepc, 10 trap vector, 11 next PC.
- `flush_out` out 1 — kill the instruction in the pipeline register.
- `set_epc_out`, `set_cause_out` out 1 each — CSR write strobes for mepc and mcause.
- `cause_out` out 4 — registered cause code.
- `i_or_e_out` out 1 — registered interrupt (1) or exception (0) flag.
- `mie_clear_out`, `mie_set_out` out 1 each — mstatus.MIE clear and set strobes.
- `misaligned_exception_out` out 1 — registered flag: cause is 0, 4 or 6 and the trap is an exception.
- `instret_inc_out` out 1 — minstret increment enable.

## Operation
**FSM states:** RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- RESET always moves to OPERATING.
- OPERATING moves to TRAP_TAKEN when `trap_taken_out` is 1.
- Otherwise OPERATING moves to TRAP_RETURN when `is_mret` is 1.
- Otherwise OPERATING stays in OPERATING.
- TRAP_TAKEN and TRAP_RETURN always move to OPERATING.

**SYSTEM decode:** SYSTEM means opcode 11100, funct3 000, and rs1 = rd = 0.
- ECALL: SYSTEM with funct7 0000000, rs2 00000.
- EBREAK: SYSTEM with funct7 0000000, rs2 00001.
- MRET: SYSTEM with funct7 0011000, rs2 00010.
- Any other SYSTEM/000 encoding causes no trap and no state change.

**Exceptions, highest priority first (cause codes):**
- misaligned_instr → 0
- illegal → 2
- EBREAK → 3
- misaligned_load → 4
- misaligned_store → 6
- ECALL → 11

**Interrupts:** taken only when `mie_in` = 1 and no exception is present.
- Priority: MEI (`meie_in & meip_in`) → 11, then MSI → 3, then MTI → 7.

**Trap detection:**
- `exc` = OR of all exception sources.
- `irq` = `mie_in` & (MEI | MSI | MTI).
- `trap_taken_out` = (state == OPERATING) & (`exc` | `irq`).
- `is_mret` = (state == OPERATING) & MRET & ~`trap_taken_out`.

**Registered cause:** on any clock edge where `trap_taken_out` = 1:
- `cause_out` ← the highest-priority cause code.
- `i_or_e_out` ← ~`exc`.
- `misaligned_exception_out` is latched the same way.
- All three hold their value at every other time.

**Output decode by state:**
- RESET: `pc_src_out` = 00, `flush_out` = 1.
- OPERATING: `pc_src_out` = 11; `instret_inc_out` = ~`trap_taken_out`.
- TRAP_TAKEN: `pc_src_out` = 10, `flush_out` = 1, `set_epc_out` = 1, `set_cause_out` = 1, `mie_clear_out` = 1.
- TRAP_RETURN: `pc_src_out` = 01, `flush_out` = 1, `mie_set_out` = 1.
- Every strobe not listed for a state is 0 in that state.

## Timing
- **Reset:** asynchronous; state becomes RESET immediately.
  - `cause_out` = 0, `i_or_e_out` = 0, `misaligned_exception_out` = 0.
  - `pc_src_out` = 00, `flush_out` = 1, all other outputs 0.
  - After deassertion, the first clock edge moves to OPERATING.
  - Reset asserted mid-trap aborts the sequence; no CSR strobes follow.
- **Trap latency:** the trap is detected in cycle N (combinational `trap_taken_out`, which suppresses the decoder store).
  - In cycle N+1 (TRAP_TAKEN) the strobes are active for exactly 1 cycle, `cause_out` is already valid, and the PC loads the vector.
  - Cycle N+2 is back in OPERATING.
- **MRET:** detected in cycle N; cycle N+1 is TRAP_RETURN for exactly 1 cycle; cycle N+2 is OPERATING.
- **Blocked states:** traps and MRET are never accepted in RESET, TRAP_TAKEN or TRAP_RETURN. Inputs are ignored in those cycles, and interrupts still pending are re-evaluated in the next OPERATING cycle.
- **Simultaneous events:**
  - An exception and an interrupt together: the exception wins, `i_or_e_out` = 0.
  - MRET and a pending interrupt together: the interrupt wins.
  - Multiple exceptions together: the priority order above applies.
- **Back-to-back:** a minimum of 2 cycles lies between consecutive trap detections.

## Test plan
- **Reset:** assert reset mid-TRAP_TAKEN → outputs at reset values immediately. Release → `pc_src_out` 00 then 11 on the next edge; `instret_inc_out` = 1 in OPERATING.
- **ECALL:** opcode 11100, funct3 000, funct7 0, rs2 0 → `trap_taken_out` = 1 in the same cycle. Next cycle: `cause_out` = 11, `i_or_e_out` = 0, `set_epc_out` = `set_cause_out` = `mie_clear_out` = 1, `pc_src_out` = 10, `flush_out` = 1. Following cycle: `pc_src_out` = 11.
- **Exception vs interrupt:** `illegal_instr_in` = 1 and `misaligned_load_in` = 1 together with `mie_in` = `meie_in` = `meip_in` = 1 → `cause_out` = 2, `i_or_e_out` = 0, `misaligned_exception_out` = 0.
- **Interrupt priority:** `mie_in` = 1, MSI and MTI both enabled and pending → `cause_out` = 3, `i_or_e_out` = 1. With `mie_in` = 0 → no trap and `instret_inc_out` = 1.
- **MRET:** funct7 0011000, rs2 00010 → next cycle `pc_src_out` = 01, `mie_set_out` = 1, `flush_out` = 1. With `meip_in` & `meie_in` & `mie_in` active in the same cycle → TRAP_TAKEN with `cause_out` = 11 instead.
- **Misaligned store:** `misaligned_store_in` = 1 → `trap_taken_out` = 1 in the same cycle, then `cause_out` = 6 and `misaligned_exception_out` = 1. Stimulus held high during TRAP_TAKEN → no second trap.
